// File: rtl/sysid_checker.sv
// ----------------------------------------------------------------------------
// sysid_checker
//
// Boot-time image check. On start, reads the system-ID slave over Avalon-MM
// (word 0 = ID, word 1 = build timestamp), compares against the expected
// constants and reports a sticky pass/fail result to the boot supervisor.
// Waitrequest stalls are bounded by a per-attempt timeout; a timed-out read
// is dropped for one cycle and then retried up to MAX_RETRIES times.
//
// Optional feature macro: SYSID_CHECK_TIMESTAMP_EN
//   defined   - the timestamp word is read and compared as well
//   undefined - only the ID word is read; captured_ts and fail_ts are tied 0
//
// Ports:
//   clock, reset       system clock, synchronous active-high reset
//   start              begin a check sequence (honoured only when idle)
//   avm_address/read   Avalon-MM master request (word address, read strobe)
//   avm_waitrequest    slave stall; data valid when read=1 and waitrequest=0
//   avm_readdata       slave read data
//   busy               sequence in progress
//   done               one-cycle completion pulse
//   pass               sticky: every enabled check matched
//   fail_id, fail_ts   sticky: ID / timestamp mismatch
//   timeout_err        sticky: read retries exhausted
//   captured_id/ts     last words read from the slave
// ----------------------------------------------------------------------------
module sysid_checker #(
   parameter logic [31:0] EXPECTED_ID    = 32'd0,
   parameter logic [31:0] EXPECTED_TS    = 32'd1305842390,
   parameter int          TIMEOUT_CYCLES = 255,
   parameter int          MAX_RETRIES    = 3
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   output logic        avm_address,
   output logic        avm_read,
   input  logic        avm_waitrequest,
   input  logic [31:0] avm_readdata,
   output logic        busy,
   output logic        done,
   output logic        pass,
   output logic        fail_id,
   output logic        fail_ts,
   output logic        timeout_err,
   output logic [31:0] captured_id,
   output logic [31:0] captured_ts
);

   localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
   localparam logic [3:0]  RETRY_LIMIT  = 4'(MAX_RETRIES);

   typedef enum logic [2:0] {IDLE, RD_ID, RD_TS, GAP, CHECK} state_t;

   state_t      state;
   state_t      retry_state;
   logic [15:0] wait_cnt;
   logic [3:0]  retry_cnt;
   logic        timed_out;
   logic        retries_left;

   // The stalled cycle that would bring the counter to TIMEOUT_CYCLES ends
   // the attempt, so an attempt spans exactly TIMEOUT_CYCLES read cycles.
   assign timed_out    = avm_waitrequest && (wait_cnt == TIMEOUT_LAST);
   assign retries_left = (retry_cnt != RETRY_LIMIT);

`ifndef SYSID_CHECK_TIMESTAMP_EN
   logic unused_expected_ts;
   assign unused_expected_ts = ^EXPECTED_TS;
   assign fail_ts            = 1'b0;
   assign captured_ts        = 32'd0;
`endif

   // Sequencer. Results are computed on the edge that enters CHECK, using the
   // word being accepted on that edge, so they are valid while done is high.
   always_ff @(posedge clock) begin
      if (reset) begin
         state       <= IDLE;
         retry_state <= RD_ID;
         wait_cnt    <= '0;
         retry_cnt   <= '0;
         avm_read    <= 1'b0;
         avm_address <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         pass        <= 1'b0;
         fail_id     <= 1'b0;
         timeout_err <= 1'b0;
         captured_id <= '0;
`ifdef SYSID_CHECK_TIMESTAMP_EN
         fail_ts     <= 1'b0;
         captured_ts <= '0;
`endif
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state       <= RD_ID;
                  retry_state <= RD_ID;
                  avm_read    <= 1'b1;
                  avm_address <= 1'b0;
                  busy        <= 1'b1;
                  wait_cnt    <= '0;
                  retry_cnt   <= '0;
                  pass        <= 1'b0;
                  fail_id     <= 1'b0;
                  timeout_err <= 1'b0;
                  captured_id <= '0;
`ifdef SYSID_CHECK_TIMESTAMP_EN
                  fail_ts     <= 1'b0;
                  captured_ts <= '0;
`endif
               end
            end

            RD_ID: begin
               if (!avm_waitrequest) begin
                  captured_id <= avm_readdata;
                  wait_cnt    <= '0;
`ifdef SYSID_CHECK_TIMESTAMP_EN
                  state       <= RD_TS;
                  avm_address <= 1'b1;
`else
                  state       <= CHECK;
                  avm_read    <= 1'b0;
                  done        <= 1'b1;
                  fail_id     <= (avm_readdata != EXPECTED_ID);
                  pass        <= (avm_readdata == EXPECTED_ID);
`endif
               end else if (timed_out) begin
                  wait_cnt <= '0;
                  avm_read <= 1'b0;
                  if (retries_left) begin
                     state       <= GAP;
                     retry_state <= RD_ID;
                  end else begin
                     state       <= CHECK;
                     done        <= 1'b1;
                     timeout_err <= 1'b1;
                  end
               end else begin
                  wait_cnt <= wait_cnt + 16'd1;
               end
            end

`ifdef SYSID_CHECK_TIMESTAMP_EN
            RD_TS: begin
               if (!avm_waitrequest) begin
                  captured_ts <= avm_readdata;
                  wait_cnt    <= '0;
                  state       <= CHECK;
                  avm_read    <= 1'b0;
                  done        <= 1'b1;
                  fail_id     <= (captured_id != EXPECTED_ID);
                  fail_ts     <= (avm_readdata != EXPECTED_TS);
                  pass        <= (captured_id == EXPECTED_ID) &&
                                 (avm_readdata == EXPECTED_TS);
               end else if (timed_out) begin
                  wait_cnt <= '0;
                  avm_read <= 1'b0;
                  if (retries_left) begin
                     state       <= GAP;
                     retry_state <= RD_TS;
                  end else begin
                     state       <= CHECK;
                     done        <= 1'b1;
                     timeout_err <= 1'b1;
                  end
               end else begin
                  wait_cnt <= wait_cnt + 16'd1;
               end
            end
`endif

            // One idle bus cycle, then re-issue the read that timed out.
            // The address register is untouched so the slave sees the same word.
            GAP: begin
               state     <= retry_state;
               avm_read  <= 1'b1;
               retry_cnt <= retry_cnt + 4'd1;
            end

            CHECK: begin
               state <= IDLE;
               busy  <= 1'b0;
            end

            default: begin
               state    <= IDLE;
               avm_read <= 1'b0;
               busy     <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sysid_checker.sv
// ----------------------------------------------------------------------------
// tb_sysid_checker
//
// Scoreboard bench for sysid_checker. Two instances: dut_a (default
// parameters) talks to a slave model with programmable stalls; dut_b
// (TIMEOUT_CYCLES=4, MAX_RETRIES=1) sees a slave that never releases
// waitrequest. Stimulus pushes the hand-computed response for each start;
// per-instance monitors pop and compare whenever done is seen.
// ----------------------------------------------------------------------------
module tb_sysid_checker;

   localparam logic [31:0] EXP_TS_WORD = 32'd1305842390;
`ifdef SYSID_CHECK_TIMESTAMP_EN
   localparam int TS = 1;
`else
   localparam int TS = 0;
`endif

   typedef struct {
      int          latency;
      int          read_cycles;
      int          addr1_cycles;
      int          gap_cycles;
      logic        pass;
      logic        fail_id;
      logic        fail_ts;
      logic        timeout_err;
      logic [31:0] cap_id;
      logic [31:0] cap_ts;
   } exp_t;

   logic        clock;
   logic        reset;
   logic        start_a, start_b;

   logic        a_addr, a_read, a_wr, a_busy, a_done, a_pass;
   logic        a_fail_id, a_fail_ts, a_timeout;
   logic [31:0] a_rdata, a_cap_id, a_cap_ts;

   logic        b_addr, b_read, b_wr, b_busy, b_done, b_pass;
   logic        b_fail_id, b_fail_ts, b_timeout;
   logic [31:0] b_rdata, b_cap_id, b_cap_ts;

   logic [31:0] cfg_id, cfg_ts;
   int          cfg_stall_id, cfg_stall_ts;
   int          id_stalls, ts_stalls;

   int          cyc;
   int          checks;
   int          failures;

   exp_t        q_a[$];
   exp_t        q_b[$];

   sysid_checker dut_a (
      .clock(clock), .reset(reset), .start(start_a),
      .avm_address(a_addr), .avm_read(a_read),
      .avm_waitrequest(a_wr), .avm_readdata(a_rdata),
      .busy(a_busy), .done(a_done), .pass(a_pass),
      .fail_id(a_fail_id), .fail_ts(a_fail_ts), .timeout_err(a_timeout),
      .captured_id(a_cap_id), .captured_ts(a_cap_ts)
   );

   sysid_checker #(.TIMEOUT_CYCLES(4), .MAX_RETRIES(1)) dut_b (
      .clock(clock), .reset(reset), .start(start_b),
      .avm_address(b_addr), .avm_read(b_read),
      .avm_waitrequest(b_wr), .avm_readdata(b_rdata),
      .busy(b_busy), .done(b_done), .pass(b_pass),
      .fail_id(b_fail_id), .fail_ts(b_fail_ts), .timeout_err(b_timeout),
      .captured_id(b_cap_id), .captured_ts(b_cap_ts)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Slave model for dut_a: stall each word for a configured number of
   // cycles, counted from the accepted start.
   assign a_wr    = a_addr ? (ts_stalls < cfg_stall_ts) : (id_stalls < cfg_stall_id);
   assign a_rdata = a_addr ? cfg_ts : cfg_id;
   assign b_wr    = 1'b1;
   assign b_rdata = 32'd0;

   initial begin
      cyc       = 0;
      id_stalls = 0;
      ts_stalls = 0;
   end

   always @(posedge clock) begin
      cyc <= cyc + 1;
      if (start_a && !a_busy) begin
         id_stalls <= 0;
         ts_stalls <= 0;
      end else if (a_read && a_wr) begin
         if (a_addr) ts_stalls <= ts_stalls + 1;
         else        id_stalls <= id_stalls + 1;
      end
   end

   task automatic checkField(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic checkOutput(input string tag, input exp_t e, input int lat, input int rc,
                              input int a1, input int gp, input logic p, input logic fi,
                              input logic ft, input logic to, input logic [31:0] ci,
                              input logic [31:0] ct);
      checkField({tag, ".latency"},      lat, e.latency);
      checkField({tag, ".read_cycles"},  rc,  e.read_cycles);
      checkField({tag, ".addr1_cycles"}, a1,  e.addr1_cycles);
      checkField({tag, ".gap_cycles"},   gp,  e.gap_cycles);
      checkField({tag, ".pass"},         p,   e.pass);
      checkField({tag, ".fail_id"},      fi,  e.fail_id);
      checkField({tag, ".fail_ts"},      ft,  e.fail_ts);
      checkField({tag, ".timeout_err"},  to,  e.timeout_err);
      checkField({tag, ".captured_id"},  ci,  e.cap_id);
      checkField({tag, ".captured_ts"},  ct,  e.cap_ts);
   endtask

   // Monitor for dut_a: profile the bus from the accepted start, compare on done.
   int a_start_cyc, a_rc, a_a1, a_gap;
   always @(negedge clock) begin
      exp_t e;
      if (start_a && !a_busy && !reset) begin
         a_start_cyc = cyc;
         a_rc = 0; a_a1 = 0; a_gap = 0;
      end else begin
         if (a_read)                       a_rc++;
         if (a_read && a_addr)             a_a1++;
         if (a_busy && !a_read && !a_done) a_gap++;
      end
      if (a_done) begin
         if (q_a.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL a.unexpected_done: got done=1, expected done=0");
         end else begin
            e = q_a.pop_front();
            checkOutput("a", e, cyc - a_start_cyc, a_rc, a_a1, a_gap, a_pass,
                        a_fail_id, a_fail_ts, a_timeout, a_cap_id, a_cap_ts);
         end
      end
   end

   // Monitor for dut_b.
   int b_start_cyc, b_rc, b_a1, b_gap;
   always @(negedge clock) begin
      exp_t e;
      if (start_b && !b_busy && !reset) begin
         b_start_cyc = cyc;
         b_rc = 0; b_a1 = 0; b_gap = 0;
      end else begin
         if (b_read)                       b_rc++;
         if (b_read && b_addr)             b_a1++;
         if (b_busy && !b_read && !b_done) b_gap++;
      end
      if (b_done) begin
         if (q_b.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL b.unexpected_done: got done=1, expected done=0");
         end else begin
            e = q_b.pop_front();
            checkOutput("b", e, cyc - b_start_cyc, b_rc, b_a1, b_gap, b_pass,
                        b_fail_id, b_fail_ts, b_timeout, b_cap_id, b_cap_ts);
         end
      end
   end

   function automatic exp_t mk(input int lat, input int rc, input int a1, input int gp,
                               input logic p, input logic fi, input logic ft,
                               input logic to, input logic [31:0] ci, input logic [31:0] ct);
      exp_t e;
      e.latency = lat; e.read_cycles = rc; e.addr1_cycles = a1; e.gap_cycles = gp;
      e.pass = p; e.fail_id = fi; e.fail_ts = ft; e.timeout_err = to;
      e.cap_id = ci; e.cap_ts = ct;
      return e;
   endfunction

   task automatic applyStimulus(input bit use_b, input logic [31:0] id, input logic [31:0] ts,
                                input int s_id, input int s_ts, input bit expect_done,
                                input exp_t e);
      repeat (2) @(posedge clock);
      #1;
      if (!use_b) begin
         cfg_id = id; cfg_ts = ts; cfg_stall_id = s_id; cfg_stall_ts = s_ts;
         if (expect_done) q_a.push_back(e);
         start_a = 1'b1;
      end else begin
         if (expect_done) q_b.push_back(e);
         start_b = 1'b1;
      end
      @(posedge clock);
      #1;
      start_a = 1'b0;
      start_b = 1'b0;
   endtask

   task automatic waitDrain();
      for (int i = 0; i < 200; i++) begin
         if (q_a.size() == 0 && q_b.size() == 0) break;
         @(negedge clock);
      end
      checks++;
      if (q_a.size() != 0 || q_b.size() != 0) begin
         failures++;
         $display("[TB] FAIL drain: got %0d pending results, expected 0", q_a.size() + q_b.size());
         q_a.delete();
         q_b.delete();
      end
   endtask

   task automatic checkReset(input string tag);
      checkField({tag, ".avm_read"},    a_read,    0);
      checkField({tag, ".avm_address"}, a_addr,    0);
      checkField({tag, ".busy"},        a_busy,    0);
      checkField({tag, ".done"},        a_done,    0);
      checkField({tag, ".pass"},        a_pass,    0);
      checkField({tag, ".fail_id"},     a_fail_id, 0);
      checkField({tag, ".fail_ts"},     a_fail_ts, 0);
      checkField({tag, ".timeout_err"}, a_timeout, 0);
      checkField({tag, ".captured_id"}, a_cap_id,  0);
      checkField({tag, ".captured_ts"}, a_cap_ts,  0);
      checkField({tag, ".b_busy"},      b_busy,    0);
      checkField({tag, ".b_read"},      b_read,    0);
   endtask

   initial begin
      checks = 0; failures = 0;
      reset = 1'b1; start_a = 1'b0; start_b = 1'b0;
      cfg_id = '0; cfg_ts = '0; cfg_stall_id = 0; cfg_stall_ts = 0;
      repeat (3) @(posedge clock);
      @(negedge clock);
      checkReset("por");
      @(posedge clock);
      #1 reset = 1'b0;

      $display("[TB] zero-wait matching image");
      applyStimulus(0, 32'd0, EXP_TS_WORD, 0, 0, 1,
                    mk(2+TS, 1+TS, TS, 0, 1, 0, 0, 0, 32'd0, (TS != 0) ? EXP_TS_WORD : 32'd0));
      waitDrain();

      $display("[TB] ID mismatch");
      applyStimulus(0, 32'd5, EXP_TS_WORD, 0, 0, 1,
                    mk(2+TS, 1+TS, TS, 0, 0, 1, 0, 0, 32'd5, (TS != 0) ? EXP_TS_WORD : 32'd0));
      waitDrain();

      $display("[TB] timestamp mismatch");
      applyStimulus(0, 32'd0, 32'd1234, 0, 0, 1,
                    mk(2+TS, 1+TS, TS, 0, TS == 0, 0, TS != 0, 0, 32'd0,
                       (TS != 0) ? 32'd1234 : 32'd0));
      waitDrain();

      $display("[TB] ten waitrequest cycles on ID read");
      applyStimulus(0, 32'd0, EXP_TS_WORD, 10, 0, 1,
                    mk(12+TS, 11+TS, TS, 0, 1, 0, 0, 0, 32'd0, (TS != 0) ? EXP_TS_WORD : 32'd0));
      waitDrain();

      $display("[TB] four waitrequest cycles on timestamp read");
      applyStimulus(0, 32'd0, EXP_TS_WORD, 0, 4, 1,
                    mk(2+5*TS, 1+5*TS, 5*TS, 0, 1, 0, 0, 0, 32'd0,
                       (TS != 0) ? EXP_TS_WORD : 32'd0));
      waitDrain();

      $display("[TB] stalled bad ID with start pulses while busy");
      applyStimulus(0, 32'd7, EXP_TS_WORD, 3, 0, 1,
                    mk(5+TS, 4+TS, TS, 0, 0, 1, 0, 0, 32'd7, (TS != 0) ? EXP_TS_WORD : 32'd0));
      @(posedge clock); #1 start_a = 1'b1;
      @(posedge clock); #1 start_a = 1'b0;
      repeat (2 + TS) @(posedge clock);
      #1 start_a = 1'b1;
      @(posedge clock); #1 start_a = 1'b0;
      waitDrain();
      repeat (4) @(negedge clock);

      $display("[TB] reset in the middle of a read");
      applyStimulus(0, 32'd9, EXP_TS_WORD, (TS != 0) ? 0 : 20, 20, 0,
                    mk(0, 0, 0, 0, 0, 0, 0, 0, 32'd0, 32'd0));
      repeat (3) @(posedge clock);
      #1 reset = 1'b1;
      @(posedge clock);
      #1 reset = 1'b0;
      @(negedge clock);
      checkReset("mid");

      $display("[TB] fresh sequence after reset");
      applyStimulus(0, 32'd0, EXP_TS_WORD, 0, 0, 1,
                    mk(2+TS, 1+TS, TS, 0, 1, 0, 0, 0, 32'd0, (TS != 0) ? EXP_TS_WORD : 32'd0));
      waitDrain();

      $display("[TB] stuck slave, timeout with one retry");
      applyStimulus(1, 32'd0, 32'd0, 0, 0, 1,
                    mk(10, 8, 0, 1, 0, 0, 0, 1, 32'd0, 32'd0));
      waitDrain();

      repeat (4) @(posedge clock);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      failures++;
      $display("[TB] FAIL watchdog: got no finish by time limit, expected finish");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "[TB] watchdog expired");
   end

endmodule

// File: doc/sysid_checker.md
# sysid_checker

Boot-time controller that sequences Avalon-MM reads of the system-ID slave (address 0 = ID word, address 1 = build timestamp), compares the results against expected constants, and reports pass/fail to the boot supervisor. It sits between the supervisor/reset logic and the `sysid` control slave. It owns the read handshake, including waitrequest stalls, timeout and retry, so software never starts on a mismatched FPGA image.

## Interface
Parameters:
- EXPECTED_ID, 32'd0, value required at address 0
- EXPECTED_TS, 32'd1305842390, value required at address 1
- TIMEOUT_CYCLES, 255, maximum waitrequest-high cycles per read attempt (1..65535)
- MAX_RETRIES, 3, retries after the first timed-out attempt (0..15)

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  begin check sequence; sampled only in IDLE
- avm_address  out  1  slave word address
- avm_read  out  1  read request
- avm_waitrequest  in  1  slave stall; data is valid in the cycle with read=1 and waitrequest=0
- avm_readdata  in  32  slave read data
- busy  out  1  sequence in progress
- done  out  1  one-cycle completion pulse
- pass  out  1  sticky result; all enabled checks matched
- fail_id  out  1  sticky; ID mismatch
- fail_ts  out  1  sticky; timestamp mismatch
- timeout_err  out  1  sticky; retries exhausted
- captured_id  out  32  last ID word read
- captured_ts  out  32  last timestamp word read

## Operation
- States: IDLE, RD_ID, RD_TS, GAP, CHECK.
- IDLE with start=1 → RD_ID. Sticky flags, captured_* and the retry counter clear on this same edge. busy=1 from the next cycle.
- RD_ID: avm_read=1, avm_address=0. An accepted cycle (waitrequest=0) latches captured_id and goes to RD_TS, or to CHECK if the macro is absent.
- RD_TS: avm_read=1, avm_address=1. An accepted cycle latches captured_ts and goes to CHECK.
- Timeout: a 16-bit counter increments on each read cycle with waitrequest=1. It resets on state entry and on acceptance. When it reaches TIMEOUT_CYCLES while waitrequest is still 1, the FSM goes to GAP. avm_read=0 in GAP for exactly 1 cycle. GAP then re-enters the same read state, and retries increments.
- If the timeout occurs with retries==MAX_RETRIES, the FSM goes to CHECK with timeout_err=1. Compares are skipped, so fail_id, fail_ts and pass stay 0.
- CHECK (1 cycle) sets fail_id = (captured_id≠EXPECTED_ID) and fail_ts = (captured_ts≠EXPECTED_TS, macro only). pass = no fail and no timeout. CHECK pulses done and returns to IDLE.
- start while not IDLE is ignored.
- avm_address holds its value while avm_read=0. avm_read never drops while waitrequest=1 except on timeout or reset.

## Timing
- Reset values: avm_read=0, avm_address=0, busy=0, done=0, pass=0, fail_id=0, fail_ts=0, timeout_err=0, captured_id=0, captured_ts=0, state IDLE.
- Reset asserted mid-sequence forces these values at the next edge. An in-flight read is abandoned.
- Zero-wait slave, start sampled at edge 0:
  - avm_read is high in cycles 1–2 (address 0 then 1).
  - CHECK is in cycle 3; done=1 in cycle 3.
  - Without the macro, CHECK and done are in cycle 2.
- Each waitrequest-high cycle adds one cycle of latency.
- A timed-out attempt costs TIMEOUT_CYCLES+1 cycles including GAP.
- Results are registered. pass/fail/timeout_err are valid in the done cycle and held until the next accepted start or reset.

## Configuration
- SYSID_CHECK_TIMESTAMP_EN defined: the timestamp read and compare are performed, as above.
- SYSID_CHECK_TIMESTAMP_EN undefined: RD_TS is unreachable and address 1 is never issued. captured_ts stays 0, fail_ts is tied 0, and pass depends on the ID and timeout only.

## Test plan
- Zero-wait slave returns 0 / 1305842390, start pulse → done in cycle 3, pass=1, captured_ts=1305842390, two reads on addresses 0,1.
- Slave returns 0x00000005 at address 0 → done, fail_id=1, pass=0, captured_id=5.
- waitrequest high for 10 cycles on the ID read → no timeout, avm_read held steady throughout, done at cycle 13, pass=1.
- waitrequest stuck high, TIMEOUT_CYCLES=4, MAX_RETRIES=1 → 2 attempts with a 1-cycle read gap between them, then done with timeout_err=1 and pass=0.
- reset asserted during RD_TS, then start → all outputs 0 after reset, and a fresh sequence completes with pass=1. A start pulse while busy has no effect.
- Macro undefined → only an address-0 read is issued, done in cycle 2, fail_ts=0.
